// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: message types, status opcodes, baud
// constants, FSM state encodings and the status-byte builder.
package midi_pkg;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;
    localparam int unsigned MIDI_BAUD  = 31_250;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        NOTE_OFF    = 2'd0,
        NOTE_ON     = 2'd1,
        PROG_CHANGE = 2'd2,
        RSVD        = 2'd3
    } msg_type_e;

    localparam logic [3:0] OP_NOTE_OFF    = 4'h8;
    localparam logic [3:0] OP_NOTE_ON     = 4'h9;
    localparam logic [3:0] OP_PROG_CHANGE = 4'hC;

    // One channel-voice message as presented on the request bus.
    typedef struct packed {
        msg_type_e           msg_type;
        logic [CHAN_W-1:0]   channel;
        logic [DATA_W-1:0]   data1;
        logic [DATA_W-1:0]   data2;
    } midi_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STATUS,
        ST_DATA1,
        ST_DATA2
    } msg_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    // Status byte {1, opcode[2:0], channel}; reserved type yields 0x00.
    function automatic logic [BYTE_W-1:0] status_byte(input msg_type_e t,
                                                      input logic [CHAN_W-1:0] ch);
        logic [BYTE_W-1:0] s;
        case (t)
            NOTE_OFF:    s = {OP_NOTE_OFF, ch};
            NOTE_ON:     s = {OP_NOTE_ON, ch};
            PROG_CHANGE: s = {OP_PROG_CHANGE, ch};
            default:     s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/midi_tx_if.sv
// Message request bus into midi_tx.
//   VALID    : message present (master -> slave)
//   READY    : slave can accept a message (slave -> master)
//   MSG_TYPE : 0 note off, 1 note on, 2 program change, 3 reserved
//   CHANNEL  : MIDI channel
//   DATA1    : note number / program
//   DATA2    : velocity (unused for program change)
interface midi_tx_if;
    import midi_pkg::*;

    logic                 VALID;
    logic                 READY;
    logic [TYPE_W-1:0]    MSG_TYPE;
    logic [CHAN_W-1:0]    CHANNEL;
    logic [DATA_W-1:0]    DATA1;
    logic [DATA_W-1:0]    DATA2;

    modport master (output VALID, MSG_TYPE, CHANNEL, DATA1, DATA2, input READY);
    modport slave  (input VALID, MSG_TYPE, CHANNEL, DATA1, DATA2, output READY);

endinterface

// File: rtl/midi_tx_uart_tx.sv
// UART 8N1 byte serializer.
//   CLK, RST_N : clock, synchronous active-low reset
//   CE         : clock enable; all state holds while low
//   START, DIN : load a byte (idle, or in the same cycle as DONE)
//   DO         : serial line, idles high (registered)
//   DONE       : combinational one-cycle pulse in the last stop-bit cycle
module uart_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              START,
    input  logic [BYTE_W-1:0] DIN,
    output logic              DO,
    output logic              DONE
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'd9;

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [3:0]         idx_q, idx_d;
    logic [BYTE_W:0]    shift_q, shift_d;
    logic               do_q, do_d;
    logic               load_c;
    logic               done_c;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '1;
            do_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            do_q    <= do_d;
        end
    end

    // Bit timing and shifting; idx 0 is the start bit, 9 the stop bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        do_d    = do_q;
        load_c  = 1'b0;
        done_c  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                load_c = CE && START;
            end
            TX_SHIFT: begin
                if (CE) begin
                    if (baud_q == CNT_LAST) begin
                        baud_d = '0;
                        if (idx_q == STOP_IDX) begin
                            done_c = 1'b1;
                            if (START) begin
                                load_c = 1'b1;
                            end else begin
                                state_d = TX_IDLE;
                                do_d    = 1'b1;
                            end
                        end else begin
                            do_d    = shift_q[0];
                            shift_d = {1'b1, shift_q[BYTE_W:1]};
                            idx_d   = idx_q + 4'd1;
                        end
                    end else begin
                        baud_d = baud_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                do_d    = 1'b1;
            end
        endcase

        // Loading drives the start bit next cycle; stop bit rides in shift[8].
        if (load_c) begin
            state_d = TX_SHIFT;
            do_d    = 1'b0;
            shift_d = {1'b1, DIN};
            idx_d   = '0;
            baud_d  = '0;
        end
    end

    assign DO   = do_q;
    assign DONE = done_c;

endmodule

// File: rtl/midi_tx.sv
// MIDI channel-voice message transmitter (8N1 serial, optional running status).
//   CLK, RST_N : clock, synchronous active-low reset
//   CE         : clock enable; all state holds while low
//   bus        : request bus (VALID/READY handshake, message fields)
//   DO         : serial output, idles high
//   BUSY       : high while any byte is on the line
module midi_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = SYS_CLK_HZ / MIDI_BAUD,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    midi_tx_if.slave    bus,
    output logic        DO,
    output logic        BUSY
);

    msg_state_e         state_q, state_d;
    logic [DATA_W-1:0]  data1_q, data1_d;
    logic [DATA_W-1:0]  data2_q, data2_d;
    logic               prog_q, prog_d;
    logic [BYTE_W-1:0]  last_status_q, last_status_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    midi_msg_t          msg_in;
    logic [BYTE_W-1:0]  status_c;
    logic               accept_c;
    logic               skip_status_c;
    logic               tx_start_c;
    logic [BYTE_W-1:0]  tx_byte_c;
    logic               tx_done_c;

    assign msg_in = '{msg_type: msg_type_e'(bus.MSG_TYPE),
                      channel:  bus.CHANNEL,
                      data1:    bus.DATA1,
                      data2:    bus.DATA2};

    assign status_c      = status_byte(msg_in.msg_type, msg_in.channel);
    assign accept_c      = bus.VALID && ready_q && CE;
    assign skip_status_c = RUNNING_STATUS && (status_c == last_status_q);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            data1_q       <= '0;
            data2_q       <= '0;
            prog_q        <= 1'b0;
            last_status_q <= 8'h00;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data1_q       <= data1_d;
            data2_q       <= data2_d;
            prog_q        <= prog_d;
            last_status_q <= last_status_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    // Message sequencing; each state names the byte currently on the line.
    always_comb begin
        state_d       = state_q;
        data1_d       = data1_q;
        data2_d       = data2_q;
        prog_d        = prog_q;
        last_status_d = last_status_q;
        ready_d       = ready_q;
        busy_d        = busy_q;
        tx_start_c    = 1'b0;
        tx_byte_c     = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // Reserved messages are swallowed: no bytes, READY stays high.
                if (accept_c && (msg_in.msg_type != RSVD)) begin
                    data1_d       = msg_in.data1;
                    data2_d       = msg_in.data2;
                    prog_d        = (msg_in.msg_type == PROG_CHANGE);
                    last_status_d = status_c;
                    ready_d       = 1'b0;
                    busy_d        = 1'b1;
                    tx_start_c    = 1'b1;
                    if (skip_status_c) begin
                        state_d   = ST_DATA1;
                        tx_byte_c = {1'b0, msg_in.data1};
                    end else begin
                        state_d   = ST_STATUS;
                        tx_byte_c = status_c;
                    end
                end
            end
            ST_STATUS: begin
                if (tx_done_c) begin
                    state_d    = ST_DATA1;
                    tx_start_c = 1'b1;
                    tx_byte_c  = {1'b0, data1_q};
                end
            end
            ST_DATA1: begin
                if (tx_done_c) begin
                    if (prog_q) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ST_DATA2;
                        tx_start_c = 1'b1;
                        tx_byte_c  = {1'b0, data2_q};
                    end
                end
            end
            ST_DATA2: begin
                if (tx_done_c) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE    (CE),
        .START (tx_start_c),
        .DIN   (tx_byte_c),
        .DO    (DO),
        .DONE  (tx_done_c)
    );

    assign bus.READY = ready_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: two instances (running status off / on),
// bit-accurate frame decoding of DO with timing and handshake checks.
module tb_midi_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    logic ce;
    bit   sel;
    bit   ce_tog;
    int   tests;
    int   fails;

    midi_tx_if if0 ();
    midi_tx_if if1 ();

    logic do0, do1, busy0, busy1;
    logic do_s, busy_s, ready_s;

    midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut0 (
        .CLK   (clk),
        .RST_N (rst_n),
        .CE    (ce),
        .bus   (if0),
        .DO    (do0),
        .BUSY  (busy0)
    );

    midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut1 (
        .CLK   (clk),
        .RST_N (rst_n),
        .CE    (ce),
        .bus   (if1),
        .DO    (do1),
        .BUSY  (busy1)
    );

    assign do_s    = sel ? do1 : do0;
    assign busy_s  = sel ? busy1 : busy0;
    assign ready_s = sel ? if1.READY : if0.READY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [1:0] t, input logic [3:0] ch,
                              input logic [6:0] d1, input logic [6:0] d2);
        if0.MSG_TYPE = t;  if0.CHANNEL = ch;  if0.DATA1 = d1;  if0.DATA2 = d2;
        if1.MSG_TYPE = t;  if1.CHANNEL = ch;  if1.DATA1 = d1;  if1.DATA2 = d2;
    endtask

    // Present a message for one accept edge; returns in the first frame cycle.
    task automatic present(input logic [1:0] t, input logic [3:0] ch,
                           input logic [6:0] d1, input logic [6:0] d2, input string tag);
        set_fields(t, ch, d1, d2);
        if (sel) if1.VALID = 1'b1;
        else     if0.VALID = 1'b1;
        check({tag, "_ready_before"}, 32'(ready_s), 32'd1);
        @(negedge clk);
    endtask

    task automatic drop_valid();
        if0.VALID = 1'b0;
        if1.VALID = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_do"},    32'(do_s),    32'd1);
        check({tag, "_ready"}, 32'(ready_s), 32'd1);
        check({tag, "_busy"},  32'(busy_s),  32'd0);
    endtask

    // Decode one 8N1 frame starting in the current cycle, checking every cycle.
    task automatic rx_frame(input logic [7:0] exp, input string tag);
        logic [7:0] got;
        logic       lvl;
        bit         bad;
        bit         len_bad;
        int         hits;
        int         cyc;
        int         exp_len;
        got     = 8'h00;
        bad     = 1'b0;
        len_bad = 1'b0;
        exp_len = ce_tog ? 2 * CPB : CPB;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = 1'b1;
            else             lvl = exp[b-1];
            hits = 0;
            cyc  = 0;
            while (hits < CPB && cyc < 4 * CPB) begin
                if (do_s !== lvl || busy_s !== 1'b1 || ready_s !== 1'b0) bad = 1'b1;
                if (b >= 1 && b <= 8) got[b-1] = do_s;
                if (ce_tog) ce = ~ce;
                else        ce = 1'b1;
                if (ce) hits++;
                cyc++;
                @(negedge clk);
            end
            if (cyc != exp_len) len_bad = 1'b1;
        end
        check({tag, "_byte"},    32'(got),     32'(exp));
        check({tag, "_framing"}, 32'(bad),     32'd0);
        check({tag, "_bitlen"},  32'(len_bad), 32'd0);
    endtask

    task automatic do_reset();
        ce    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit bad;
        tests  = 0;
        fails  = 0;
        sel    = 1'b0;
        ce_tog = 1'b0;
        ce     = 1'b1;
        rst_n  = 1'b0;
        drop_valid();
        set_fields(2'd0, 4'd0, 7'd0, 7'd0);
        @(negedge clk);
        do_reset();

        // Reset state of both instances (reset applied with CE low).
        sel = 1'b0; idle_check("rst0");
        sel = 1'b1; idle_check("rst1");

        // No running status: full three-byte note on.
        sel = 1'b0;
        present(2'd1, 4'd3, 7'd60, 7'd100, "t1");
        drop_valid();
        rx_frame(8'h93, "t1_status");
        rx_frame(8'h3C, "t1_data1");
        rx_frame(8'h64, "t1_data2");
        idle_check("t1_end");

        // Running status, second message streamed with VALID held high.
        sel = 1'b1;
        do_reset();
        present(2'd1, 4'd3, 7'd60, 7'd100, "t2a");
        set_fields(2'd1, 4'd3, 7'd64, 7'd100);
        rx_frame(8'h93, "t2a_status");
        rx_frame(8'h3C, "t2a_data1");
        rx_frame(8'h64, "t2a_data2");
        present(2'd1, 4'd3, 7'd64, 7'd100, "t2b");
        drop_valid();
        rx_frame(8'h40, "t2b_data1");
        rx_frame(8'h64, "t2b_data2");
        idle_check("t2_end");

        // Status changes: note on, note off, program change.
        do_reset();
        present(2'd1, 4'd3, 7'd60, 7'd100, "t3a");
        drop_valid();
        rx_frame(8'h93, "t3a_status");
        rx_frame(8'h3C, "t3a_data1");
        rx_frame(8'h64, "t3a_data2");
        present(2'd0, 4'd3, 7'd60, 7'd0, "t3b");
        drop_valid();
        rx_frame(8'h83, "t3b_status");
        rx_frame(8'h3C, "t3b_data1");
        rx_frame(8'h00, "t3b_data2");
        present(2'd2, 4'd3, 7'd5, 7'd77, "t3c");
        drop_valid();
        rx_frame(8'hC3, "t3c_status");
        rx_frame(8'h05, "t3c_data1");
        idle_check("t3c_end");

        // Reserved type is swallowed; next note on ch 0 still carries status.
        do_reset();
        present(2'd3, 4'd0, 7'd1, 7'd2, "t4r");
        drop_valid();
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (do_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        check("t4_rsvd_quiet", 32'(bad), 32'd0);
        present(2'd1, 4'd0, 7'd1, 7'd2, "t4n");
        drop_valid();
        rx_frame(8'h90, "t4n_status");
        rx_frame(8'h01, "t4n_data1");
        rx_frame(8'h02, "t4n_data2");
        idle_check("t4_end");

        // Reset during data bit 4 of DATA1 truncates and clears last_status.
        do_reset();
        present(2'd1, 4'd3, 7'd60, 7'd100, "t5a");
        drop_valid();
        rx_frame(8'h93, "t5a_status");
        repeat (5 * CPB + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        idle_check("t5_midreset");
        rst_n = 1'b1;
        @(negedge clk);
        present(2'd1, 4'd3, 7'd60, 7'd100, "t5b");
        drop_valid();
        rx_frame(8'h93, "t5b_status");
        rx_frame(8'h3C, "t5b_data1");
        rx_frame(8'h64, "t5b_data2");
        idle_check("t5_end");

        // CE toggling every other cycle stretches each bit to 2*CPB cycles.
        do_reset();
        present(2'd2, 4'd0, 7'h7F, 7'd0, "t6");
        drop_valid();
        ce_tog = 1'b1;
        rx_frame(8'hC0, "t6_status");
        rx_frame(8'h7F, "t6_data1");
        ce_tog = 1'b0;
        ce     = 1'b1;
        idle_check("t6_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Transmit-side counterpart of the MIDI receive path (UART receiver plus MIDI interpreter).
- Accepts one channel-voice message per handshake and encodes it into MIDI bytes, with optional running status.
- Serializes the bytes as UART 8N1 on DO.
- Used to echo or forward note and program events from the synth to an external MIDI device or the loopback bench.

Parameters:
- CLKS_PER_BIT, 1600, CLK cycles per UART bit (50 MHz / 31250 baud); legal range ≥ 2.
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last transmitted status byte.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous reset, active-low
- CE  in  1  clock enable; when low all state, including the baud counter, holds
- VALID  in  1  message present on MSG_TYPE/CHANNEL/DATA1/DATA2
- READY  out  1  block can accept a message
- MSG_TYPE  in  2  0 = note off (0x8n), 1 = note on (0x9n), 2 = program change (0xCn), 3 = reserved
- CHANNEL  in  4  MIDI channel n
- DATA1  in  7  note number or program
- DATA2  in  7  velocity; ignored for program change
- DO  out  1  serial output, idles high
- BUSY  out  1  high while any byte is being shifted out

Behaviour:
- Reset (RST_N low at a CLK edge with CE high or low): DO = 1, READY = 1, BUSY = 0, FSM = IDLE, baud and bit counters = 0, last_status = 0x00 (invalid, so the next status byte is always sent).
- Handshake: transfer occurs when VALID & READY & CE at a rising edge.
  - All inputs are latched at the transfer edge.
  - READY is low from the next cycle until the FSM returns to IDLE.
  - VALID may drop or change afterwards without effect.
- MSG_TYPE = 3: accepted but discarded. READY stays high; no bytes are sent; last_status is unchanged.
- Status byte = {1, opcode[2:0], CHANNEL}, with opcode 000 / 001 / 100 for types 0 / 1 / 2.
- Data bytes are {0, DATAx}; bit 7 is always 0.
- FSM states: IDLE -> STATUS -> DATA1 -> [DATA2] -> IDLE.
  - STATUS is skipped when RUNNING_STATUS = 1 and status == last_status.
  - DATA2 is skipped for program change.
  - last_status is updated when the status byte is queued, or when it is skipped.
- Byte serializer, per byte:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT CE-qualified cycles; one byte is 10·CLKS_PER_BIT cycles.
- Timing:
  - The first bit (start) appears on DO on the cycle after the accept edge.
  - Consecutive bytes of one message are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
  - READY rises on the cycle after the last stop bit completes.
  - A message presented with VALID held high is accepted on that same cycle, so messages can stream with zero idle bits.
- BUSY is high from the first start-bit cycle through the last stop-bit cycle.
- Reset mid-frame: DO returns high on the next cycle, the frame is truncated, and last_status is cleared. The receiver sees a framing error, which is acceptable.
- CE low mid-bit: DO holds its current level and the bit time is stretched by the number of CE-low cycles.

Decomposition:
- Shared package `midi_pkg`:
  - message-type enum (NOTE_OFF, NOTE_ON, PROG_CHANGE, RSVD)
  - status opcode constants 0x8, 0x9, 0xC
  - MIDI baud constant 31250
- Sub-module `uart_tx`: parameter CLKS_PER_BIT; ports CLK, RST_N, CE, START, DIN[7:0], DO, DONE.
  - Mirror of the existing uart_rx.
  - DONE pulses for one cycle at the end of the stop bit.
  - Accepts START in the same cycle as DONE, which gives the back-to-back behaviour.
- `midi_tx` contains the message FSM and running-status register only.

Test Plan:
- CLKS_PER_BIT = 4, RUNNING_STATUS = 0. Note on, ch 3, DATA1 = 60, DATA2 = 100 -> DO shows bytes 0x93, 0x3C, 0x64. Frames are 40 cycles each, no gaps; READY is low for 120 cycles, then high.
- RUNNING_STATUS = 1. Two note-ons on ch 3 (60/100, then 64/100) -> bytes 0x93 0x3C 0x64 0x40 0x64; the second message takes 80 cycles.
- RUNNING_STATUS = 1. Note on ch 3, then note off ch 3 (60/0), then program change ch 3 program 5 -> 0x93 0x3C 0x64, 0x83 0x3C 0x00, 0xC3 0x05. The program change sends no DATA2.
- MSG_TYPE = 3 -> DO stays high, BUSY stays 0, READY stays high. A following note on ch 0 still sends status 0x90.
- RST_N low during bit 4 of DATA1 -> DO = 1 and READY = 1 the next cycle. A repeat of the same note-on sends the status byte again (last_status was cleared).
- CE toggling 1-of-2 cycles during program change ch 0 program 0x7F -> each bit lasts 8 CLK cycles; bytes 0xC0 0x7F are decoded correctly by uart_rx running under the same CE.
